// File: rtl/pdm_decimator_mc.sv
// Multi-channel PDM-to-PCM decimator: counts ones per channel over a DECIM-cycle window and
// emits signed PCM samples through a valid/ready register, discarding WARMUP windows after enable.
module pdm_decimator_mc #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DECIM  = 64,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned WARMUP = 2
) (
  input  logic                   clk_2MHz,
  input  logic                   btnRST_n,
  input  logic                   en,
  input  logic [NCH-1:0]         pdm_in,
  output logic [NCH*OUT_W-1:0]   pcm_data,
  output logic                   pcm_valid,
  input  logic                   pcm_ready,
  output logic                   overrun,
  output logic                   busy
);

  localparam int unsigned L  = $clog2(DECIM);
  localparam int unsigned CW = L + 1;
  localparam int unsigned SH = OUT_W - 1 - L;

  localparam logic [L-1:0]     LastPhase = L'(DECIM - 1);
  localparam logic [OUT_W:0]   DecimExt  = (OUT_W + 1)'(DECIM);
  localparam logic [OUT_W-1:0] MaxCode   = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [3:0]       WarmupW   = 4'(WARMUP);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e                  state;
  logic [L-1:0]            phase;
  logic [3:0]              wcnt;
  logic [NCH-1:0][CW-1:0]  ones;
  logic [NCH-1:0][CW-1:0]  k;
  logic [NCH*OUT_W-1:0]    sample;
  logic                    last;

  assign last = (phase == LastPhase);

  // k includes the bit on the current edge so the final bit of a window is never lost.
  always_comb begin
    k      = '0;
    sample = '0;
    for (int c = 0; c < NCH; c++) begin
      logic [OUT_W:0] kx;
      logic [OUT_W:0] s;
      k[c]      = ones[c] + CW'(pdm_in[c]);
      kx        = '0;
      kx[CW:0]  = {k[c], 1'b0};
      s         = (kx - DecimExt) << SH;
      // Only K=DECIM lands on +2^(OUT_W-1), which is positive but has the sign bit set.
      sample[c*OUT_W +: OUT_W] = (!s[OUT_W] && s[OUT_W-1]) ? MaxCode : s[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_2MHz or negedge btnRST_n) begin
    if (!btnRST_n) begin
      state     <= StIdle;
      phase     <= '0;
      wcnt      <= '0;
      ones      <= '0;
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else if (!en) begin
      state     <= StIdle;
      phase     <= '0;
      wcnt      <= '0;
      ones      <= '0;
      pcm_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          state   <= (WARMUP > 0) ? StWarmup : StRun;
          busy    <= 1'b1;
          overrun <= 1'b0;
        end
        StWarmup: begin
          phase <= phase + 1'b1;
          if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;
          if (last) begin
            ones <= '0;
            wcnt <= wcnt + 4'd1;
            if (wcnt + 4'd1 == WarmupW) state <= StRun;
          end else begin
            ones <= k;
          end
        end
        StRun: begin
          phase <= phase + 1'b1;
          if (last) begin
            ones <= '0;
            if (!pcm_valid || pcm_ready) begin
              pcm_data  <= sample;
              pcm_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            ones <= k;
            if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_decimator_mc.sv
// Scoreboard bench for pdm_decimator_mc (NCH=2, DECIM=16, OUT_W=16, WARMUP=1) plus a
// WARMUP=0 instance sharing the same stimulus for the no-warm-up latency check.
module tb_pdm_decimator_mc;

  logic        clk_2MHz  = 1'b0;
  logic        btnRST_n  = 1'b0;
  logic        en        = 1'b0;
  logic        pcm_ready = 1'b0;
  logic [1:0]  pdm_in    = 2'b00;
  logic [31:0] pcm_data;
  logic        pcm_valid, overrun, busy;
  logic [31:0] pcm_data0;
  logic        pcm_valid0, overrun0, busy0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  pdm_decimator_mc #(.NCH(2), .DECIM(16), .OUT_W(16), .WARMUP(1)) dut (
    .clk_2MHz (clk_2MHz),
    .btnRST_n (btnRST_n),
    .en       (en),
    .pdm_in   (pdm_in),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  pdm_decimator_mc #(.NCH(2), .DECIM(16), .OUT_W(16), .WARMUP(0)) dut0 (
    .clk_2MHz (clk_2MHz),
    .btnRST_n (btnRST_n),
    .en       (en),
    .pdm_in   (pdm_in),
    .pcm_data (pcm_data0),
    .pcm_valid(pcm_valid0),
    .pcm_ready(pcm_ready),
    .overrun  (overrun0),
    .busy     (busy0)
  );

  always #5 clk_2MHz = ~clk_2MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] p);
    int kk;
    kk = $countones(p);
    if (kk == 16) return 16'h7fff;
    return 16'((2 * kk - 16) * 2048);
  endfunction

  function automatic logic [31:0] model2(input logic [15:0] p0, input logic [15:0] p1);
    return {model(p1), model(p0)};
  endfunction

  task automatic expect_win(input logic [15:0] p0, input logic [15:0] p1);
    sb.push_back(model2(p0, p1));
  endtask

  task automatic tick();
    @(posedge clk_2MHz);
    #1;
  endtask

  task automatic drive_bits(input logic [15:0] p0, input logic [15:0] p1, input int lo,
                            input int hi);
    for (int i = lo; i <= hi; i++) begin
      pdm_in = {p1[i], p0[i]};
      tick();
    end
  endtask

  // A handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk_2MHz) begin
    if (btnRST_n && pcm_valid && pcm_ready) begin
      if (sb.size() == 0) check("sb_unexpected", 32'(sb.size()), 32'd1);
      else check("sb_sample", pcm_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r0, r1;
    logic [31:0] junk;
    logic [15:0] t0[3];
    logic [15:0] t1[3];
    t0 = '{16'h0000, 16'h0001, 16'h1234};
    t1 = '{16'hFFFF, 16'h7FFF, 16'hBEEF};

    // Reset and first-sample timing
    en = 1'b1; pcm_ready = 1'b1; btnRST_n = 1'b0;
    repeat (3) tick();
    check("rst_data", pcm_data, 32'd0);
    check("rst_valid", 32'(pcm_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    btnRST_n = 1'b1;
    tick();
    check("busy_edge1", 32'(busy), 32'd1);
    r0 = 16'($urandom); r1 = 16'($urandom);
    drive_bits(r0, r1, 0, 14);
    check("w0_valid_e16", 32'(pcm_valid0), 32'd0);
    drive_bits(r0, r1, 15, 15);
    check("w0_valid_e17", 32'(pcm_valid0), 32'd1);
    check("valid_e17", 32'(pcm_valid), 32'd0);
    expect_win(16'hFFFF, 16'h0000);
    drive_bits(16'hFFFF, 16'h0000, 0, 14);
    check("valid_e32", 32'(pcm_valid), 32'd0);
    drive_bits(16'hFFFF, 16'h0000, 15, 15);
    check("valid_e33", 32'(pcm_valid), 32'd1);
    check("extremes", pcm_data, 32'h8000_7fff);

    // Code patterns
    expect_win(16'hAAAA, 16'h0FFF);
    drive_bits(16'hAAAA, 16'h0FFF, 0, 15);
    check("alt_twelve", pcm_data, 32'h4000_0000);
    for (int i = 0; i < 3; i++) begin
      expect_win(t0[i], t1[i]);
      drive_bits(t0[i], t1[i], 0, 15);
    end

    // Simultaneous accept on a final edge
    expect_win(16'h003F, 16'h1FFF);
    drive_bits(16'h003F, 16'h1FFF, 0, 0);
    pcm_ready = 1'b0;
    drive_bits(16'h003F, 16'h1FFF, 1, 15);
    check("d_loaded", 32'(pcm_valid), 32'd1);
    expect_win(16'h7FFF, 16'h0000);
    drive_bits(16'h7FFF, 16'h0000, 0, 14);
    check("d_held", pcm_data, model2(16'h003F, 16'h1FFF));
    pcm_ready = 1'b1;
    drive_bits(16'h7FFF, 16'h0000, 15, 15);
    check("simul_valid", 32'(pcm_valid), 32'd1);
    check("simul_data", pcm_data, model2(16'h7FFF, 16'h0000));
    check("simul_overrun", 32'(overrun), 32'd0);

    // Backpressure across two window ends
    expect_win(16'h0F00, 16'hF0FF);
    drive_bits(16'h0F00, 16'hF0FF, 0, 0);
    pcm_ready = 1'b0;
    drive_bits(16'h0F00, 16'hF0FF, 1, 15);
    check("a_valid", 32'(pcm_valid), 32'd1);
    check("a_overrun", 32'(overrun), 32'd0);
    drive_bits(16'hFFFF, 16'hFFFF, 0, 7);
    check("bp_stable", pcm_data, model2(16'h0F00, 16'hF0FF));
    drive_bits(16'hFFFF, 16'hFFFF, 8, 15);
    check("bp_overrun", 32'(overrun), 32'd1);
    check("bp_data", pcm_data, model2(16'h0F00, 16'hF0FF));
    check("bp_valid", 32'(pcm_valid), 32'd1);
    pcm_ready = 1'b1;
    expect_win(16'h5555, 16'h0003);
    drive_bits(16'h5555, 16'h0003, 0, 14);
    pcm_ready = 1'b0;
    drive_bits(16'h5555, 16'h0003, 15, 15);
    check("c_loaded", 32'(pcm_valid), 32'd1);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Disable mid-window with a pending sample, then re-enable
    drive_bits(16'hFFFF, 16'hFFFF, 0, 4);
    check("c_pending", 32'(sb.size()), 32'd1);
    en = 1'b0;
    tick();
    check("dis_valid", 32'(pcm_valid), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_overrun", 32'(overrun), 32'd1);
    junk = sb.pop_front();
    en = 1'b1; pcm_ready = 1'b1;
    tick();
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_overrun", 32'(overrun), 32'd0);
    r0 = 16'($urandom); r1 = 16'($urandom);
    drive_bits(r0, r1, 0, 15);
    check("rearm_warmup_valid", 32'(pcm_valid), 32'd0);
    expect_win(16'h0FFF, 16'h0007);
    drive_bits(16'h0FFF, 16'h0007, 0, 14);
    check("rearm_valid_pre", 32'(pcm_valid), 32'd0);
    pcm_ready = 1'b0;
    drive_bits(16'h0FFF, 16'h0007, 15, 15);
    check("rearm_valid", 32'(pcm_valid), 32'd1);

    // Asynchronous reset between edges in RUN
    drive_bits(16'hFFFF, 16'hFFFF, 0, 3);
    #1;
    btnRST_n = 1'b0;
    #1;
    check("arst_data", pcm_data, 32'd0);
    check("arst_valid", 32'(pcm_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("f_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    tick();
    pcm_ready = 1'b1; en = 1'b1; btnRST_n = 1'b1;
    tick();
    check("arst_busy_edge1", 32'(busy), 32'd1);
    r0 = 16'($urandom); r1 = 16'($urandom);
    drive_bits(r0, r1, 0, 15);
    expect_win(16'h8001, 16'hFFFE);
    drive_bits(16'h8001, 16'hFFFE, 0, 14);
    check("arst_valid_e32", 32'(pcm_valid), 32'd0);
    drive_bits(16'h8001, 16'hFFFE, 15, 15);
    check("arst_valid_e33", 32'(pcm_valid), 32'd1);
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_valid", 32'(pcm_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
